mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with stalling data-memory handshake and MEM/WB register.
// Optional MEM_TIMEOUT_EN adds an 8-bit WAIT watchdog and a sticky mem_err output.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ex_alu_res,
    input  logic [15:0] ex_store_data,
    input  logic [2:0]  ex_op_dest,
    input  logic        ex_mem_write_en,
    input  logic        ex_wb_mux,
    input  logic        ex_wb_en,
    input  logic [3:0]  opcode_ex_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic [15:0] mem_alu_res,
    output logic [15:0] mem_rdata,
    output logic [2:0]  mem_op_dest,
    output logic        mem_wb_mux,
    output logic        mem_wb_en,
    output logic [3:0]  opcode_mem_wb,
    output logic [15:0] mem_fwd_res
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        mem_err
`endif
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t     state, nxt;
    logic       mem_op, tmo;
    logic [2:0] lat_dest;
    logic       lat_wb_mux, lat_wb_en;
    logic [3:0] lat_opcode;
    assign mem_op = ex_mem_write_en | ex_wb_mux;
    assign mem_fwd_res = mem_wb_mux ? mem_rdata : mem_alu_res;
`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt;
    assign tmo = (state == WAIT) && (cnt == 8'hff) && !dmem_ack;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            cnt <= (state == WAIT) ? cnt + 8'd1 : 8'd0;
            if (tmo) mem_err <= 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif
    // A timed-out op releases the stall so the upstream drops it instead of retrying forever.
    always_comb begin
        nxt       = state;
        mem_stall = 1'b0;
        if (state == IDLE) begin
            mem_stall = mem_op;
            nxt       = mem_op ? WAIT : IDLE;
        end else begin
            mem_stall = !dmem_ack && !tmo;
            nxt       = (dmem_ack || tmo) ? IDLE : WAIT;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            lat_dest      <= '0;
            lat_wb_mux    <= 1'b0;
            lat_wb_en     <= 1'b0;
            lat_opcode    <= '0;
            mem_alu_res   <= '0;
            mem_rdata     <= '0;
            mem_op_dest   <= '0;
            mem_wb_mux    <= 1'b0;
            mem_wb_en     <= 1'b0;
            opcode_mem_wb <= '0;
        end else begin
            state         <= nxt;
            mem_alu_res   <= '0;
            mem_rdata     <= '0;
            mem_op_dest   <= '0;
            mem_wb_mux    <= 1'b0;
            mem_wb_en     <= 1'b0;
            opcode_mem_wb <= '0;
            if (state == IDLE) begin
                if (mem_op) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= ex_mem_write_en;
                    dmem_addr  <= ex_alu_res;
                    dmem_wdata <= ex_store_data;
                    lat_dest   <= ex_op_dest;
                    lat_wb_mux <= ex_wb_mux;
                    lat_wb_en  <= ex_wb_en;
                    lat_opcode <= opcode_ex_mem;
                end else begin
                    mem_alu_res   <= ex_alu_res;
                    mem_op_dest   <= ex_op_dest;
                    mem_wb_en     <= ex_wb_en;
                    opcode_mem_wb <= opcode_ex_mem;
                end
            end else if (dmem_ack) begin
                dmem_req      <= 1'b0;
                dmem_we       <= 1'b0;
                mem_alu_res   <= dmem_addr;
                mem_rdata     <= lat_wb_mux ? dmem_rdata : 16'h0;
                mem_op_dest   <= lat_dest;
                mem_wb_mux    <= lat_wb_mux;
                mem_wb_en     <= lat_wb_en;
                opcode_mem_wb <= lat_opcode;
            end else if (tmo) begin
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
            end
        end
    end
endmodule
